// File: rtl/clk_divider_if.sv
// clk_divider_if: control/status bundle for the programmable clock divider.
//   master : drives enable, half_period, load; observes the generated outputs.
//   slave  : the divider itself.
//   enable       count enable (low freezes the generator)
//   half_period  requested half-period, captured when load=1
//   load         single-cycle capture request
//   clk_out      generated square wave
//   rise_stb     one-cycle pulse in the first high cycle of clk_out
//   fall_stb     one-cycle pulse in the first low cycle of clk_out
//   active_half  half-period currently in use
//   pending      a captured half-period is waiting for a falling boundary
interface clk_divider_if #(
    parameter int WIDTH = 32
);
    logic             enable;
    logic [WIDTH-1:0] half_period;
    logic             load;
    logic             clk_out;
    logic             rise_stb;
    logic             fall_stb;
    logic [WIDTH-1:0] active_half;
    logic             pending;

    modport master (
        output enable, half_period, load,
        input  clk_out, rise_stb, fall_stb, active_half, pending
    );

    modport slave (
        input  enable, half_period, load,
        output clk_out, rise_stb, fall_stb, active_half, pending
    );
endinterface

// File: rtl/clk_divider.sv
// clk_divider: programmable square-wave / edge-strobe generator.
//   clk    system clock, all state on its rising edge
//   reset  synchronous, active-high
//   bus    clk_divider_if.slave (enable, half_period, load in;
//          clk_out, rise_stb, fall_stb, active_half, pending out)
// clk_out toggles every active_half enabled cycles. New half-periods are
// only applied at a falling boundary so a full period never mixes two
// different half-periods. All outputs are registered.
module clk_divider #(
    parameter int WIDTH        = 32,
    parameter int DEFAULT_HALF = 1136
) (
    input  logic          clk,
    input  logic          reset,
    clk_divider_if.slave  bus
);
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
    localparam logic [WIDTH-1:0] RESET_HALF = (DEFAULT_HALF < 1) ? ONE : WIDTH'(DEFAULT_HALF);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] active_half;
    logic [WIDTH-1:0] pend_val;
    logic             pending;
    logic             clk_out;
    logic             rise_stb;
    logic             fall_stb;
    logic             terminal;
    logic [WIDTH-1:0] req_half;

    // A zero half-period would never reach a terminal count; store it as 1.
    assign req_half = (bus.half_period == '0) ? ONE : bus.half_period;

    // active_half is never 0, so the subtraction cannot wrap.
    assign terminal = (count == active_half - ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            clk_out     <= 1'b0;
            rise_stb    <= 1'b0;
            fall_stb    <= 1'b0;
            active_half <= RESET_HALF;
            pend_val    <= '0;
            pending     <= 1'b0;
        end else begin
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;

            // Capture is independent of enable; a later load overwrites.
            if (bus.load) begin
                pend_val <= req_half;
                pending  <= 1'b1;
            end

            if (bus.enable) begin
                if (terminal) begin
                    count    <= '0;
                    clk_out  <= ~clk_out;
                    rise_stb <= ~clk_out;
                    fall_stb <= clk_out;
                    // Falling boundary: a value presented this very cycle
                    // wins over an older pending one, and nothing is left
                    // pending either way.
                    if (clk_out) begin
                        if (bus.load) begin
                            active_half <= req_half;
                            pending     <= 1'b0;
                        end else if (pending) begin
                            active_half <= pend_val;
                            pending     <= 1'b0;
                        end
                    end
                end else begin
                    count <= count + ONE;
                end
            end
        end
    end

    assign bus.clk_out     = clk_out;
    assign bus.rise_stb    = rise_stb;
    assign bus.fall_stb    = fall_stb;
    assign bus.active_half = active_half;
    assign bus.pending     = pending;
endmodule

// File: doc/clk_divider.md
Name: clk_divider

Overview:
- Programmable clock-enable/square-wave generator.
- Produces a slow clock (`clk_out`) from the system clock. `clk_out` is the source side of the slow-clock path consumed downstream by the clock synchronizer.
- Also produces single-cycle rise/fall strobes, so same-domain logic can act on slow-clock edges without resynchronizing.
- Used for audio sample-rate and LED/tick generation, with a half-period that can be reloaded at runtime.

Parameters:
- `WIDTH`, 32, width of the half-period register and counter.
- `DEFAULT_HALF`, 1136, half-period in clk cycles loaded at reset (≈22 kHz from 50 MHz).

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  count enable; when low, the whole generator freezes.
- `half_period`  in  WIDTH  requested half-period in clk cycles; sampled only when `load`=1.
- `load`  in  1  single-cycle request to capture `half_period`.
- `clk_out`  out  1  generated square wave, registered.
- `rise_stb`  out  1  high for one cycle, in the first cycle `clk_out`=1 after a 0→1 toggle.
- `fall_stb`  out  1  high for one cycle, in the first cycle `clk_out`=0 after a 1→0 toggle.
- `active_half`  out  WIDTH  half-period currently in use.
- `pending`  out  1  a loaded value is waiting to be applied.

Behaviour:
- Reset (sync, active-high; clk and reset only, as already decided):
  - count=0, `clk_out`=0, `rise_stb`=`fall_stb`=0, `active_half`=max(`DEFAULT_HALF`,1), `pending`=0, pending value discarded.
  - Reset mid-operation takes effect at the next edge, regardless of other inputs.
- Clamp rule: a `half_period` of 0 is stored as 1, so the minimum output period is 2 clk cycles.
- Counting:
  - While `enable`=1, count increments by 1 each cycle.
  - When count == `active_half`−1 (the terminal cycle), the next edge sets count=0, toggles `clk_out`, and pulses the matching strobe.
  - `f_out` = `f_clk` / (2·`active_half`); duty cycle is exactly 50%.
- `enable`=0: count, `clk_out` and `pending` hold; strobes are 0.
  - Any phase interrupted by `enable`=0 is stretched by exactly the number of disabled cycles.
  - `load` is still accepted while disabled.
- Strobes are registered alongside `clk_out`; they are never both 1, and never 1 in consecutive cycles unless `active_half`=1.
- Load handling:
  - `load`=1 captures clamp(`half_period`) into the pending register and sets `pending`=1. A later load overwrites an earlier pending value.
  - The pending value is applied only at a falling boundary: the terminal cycle with `clk_out`=1 and `enable`=1. On that edge `active_half` takes the new value, `pending` clears, and count resets to 0. A full period therefore never mixes two half-periods.
  - If `load`=1 in the falling-boundary cycle itself, the newly presented value is applied at that edge (it beats the older pending value) and `pending` stays 0.
  - A load at a rising boundary (`clk_out`=0 terminal) does not apply immediately; it waits for the next falling boundary.
- If `active_half` is changed while count > new−1, this cannot happen because the change always coincides with count reset.
- No combinational path from inputs to outputs.

Test Plan (bench overrides `DEFAULT_HALF`=3; cycle 0 = first cycle after reset deasserts; `enable`=1 unless stated):
- Free run: `clk_out`=0 in cycles 0–2, 1 in cycles 3–5, 0 in cycles 6–8. `rise_stb` is 1 only in cycle 3; `fall_stb` is 1 only in cycle 6.
- Load 5 in cycle 4 (mid high phase): `pending`=1 from cycle 5 and high phase still ends at cycle 5. `fall_stb` in cycle 6, `pending`=0, `active_half`=5; `clk_out` low in cycles 6–10, high in cycles 11–15.
- Load 0: after the next falling boundary `active_half`=1. `clk_out` then toggles every cycle and the strobes alternate every cycle.
- Drop `enable` for 4 cycles starting cycle 1: `clk_out` low phase spans cycles 0–6 (3+4), `rise_stb` occurs in cycle 7, and there are no strobes while disabled.
- Load 7 in cycle 5 (falling-boundary cycle, with an older pending 4 loaded in cycle 3): `active_half`=7 from cycle 6 and `pending`=0. The low phase lasts 7 cycles.
- Assert `reset` in cycle 4 with `pending`=1: the next cycle shows `clk_out`=0, `pending`=0, `active_half`=3, and the free-run timing restarts exactly as in scenario 1.
- Optional system check: route `clk_out` into the downstream clock synchronizer and confirm its output toggles once per `clk_out` half-period, delayed by the synchronizer latency.
